// File: rtl/spi_display_if.sv
// Host handshake and SPI pins of the 7-segment display driver.
// The host drives ena/start/digits_in; the driver owns the rest.
interface spi_display_if #(
   parameter int unsigned NUM_DIGITS = 6
);
   logic                    ena;
   logic                    start;
   logic [4*NUM_DIGITS-1:0] digits_in;
   logic                    ready;
   logic                    busy;
   logic                    done;
   logic                    cs_n;
   logic                    sck;
   logic                    mosi;

   modport master (
      output ena, start, digits_in,
      input  ready, busy, done,
      input  cs_n, sck, mosi
   );

   modport slave (
      input  ena, start, digits_in,
      output ready, busy, done,
      output cs_n, sck, mosi
   );
endinterface

// File: rtl/spi_display_driver.sv
// SPI driver for a MAX7219-style 7-segment controller: init
// sequence after reset, then one BCD word per digit per refresh.
module spi_display_driver #(
   parameter int unsigned NUM_DIGITS = 6,
   parameter int unsigned SCK_DIV    = 2,
   parameter logic [3:0]  INTENSITY  = 4'h8,
   parameter logic [7:0]  DP_MASK    = 8'b0001_0100
) (
   input logic          clk,
   input logic          rst_n,
   spi_display_if.slave bus
);

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_GAP
   } state_t;

   localparam logic [8:0] DIV_LAST = 9'(SCK_DIV - 1);
   localparam logic [8:0] GAP_LAST = 9'(2 * SCK_DIV - 1);
   localparam logic [2:0] INIT_END = 3'd4;
   localparam logic [2:0] DIG_END  = 3'(NUM_DIGITS - 1);
   localparam logic [7:0] DEC_MASK = 8'((1 << NUM_DIGITS) - 1);
   localparam logic [7:0] SCAN_LIM = 8'(NUM_DIGITS - 1);

   state_t                  state_q, state_d;
   logic [8:0]              cnt_q, cnt_d;
   logic                    half_q, half_d;
   logic [3:0]              bit_q, bit_d;
   logic [2:0]              widx_q, widx_d;
   logic                    init_q, init_d;
   logic                    pend_q, pend_d;
   logic [4*NUM_DIGITS-1:0] dig_q, dig_d;

   logic        active;
   logic        launch;
   logic [3:0]  nib;
   logic [3:0]  addr;
   logic [15:0] word;

   // The word on the wire is always derived from the current index.
   always_comb begin
      nib  = dig_q[{widx_q, 2'b00} +: 4];
      addr = {1'b0, widx_q} + 4'd1;
      word = {4'h0, addr, DP_MASK[widx_q], 3'b000, nib};
      if (init_q) begin
         case (widx_q)
            3'd0:    word = 16'h0C01;
            3'd1:    word = {8'h09, DEC_MASK};
            3'd2:    word = {8'h0B, SCAN_LIM};
            3'd3:    word = {8'h0A, 4'h0, INTENSITY};
            default: word = 16'h0F00;
         endcase
      end
   end

   assign active = (state_q == S_LOAD) ||
                   (state_q == S_SHIFT);
   assign launch = bus.ena & (pend_q | bus.start);

   assign bus.cs_n  = ~active;
   assign bus.sck   = active & half_q;
   assign bus.mosi  = active & word[bit_q];
   assign bus.done  = (state_q == S_GAP) &&
                      (cnt_q == GAP_LAST) &&
                      !init_q && (widx_q == DIG_END);
   assign bus.busy  = ((state_q != S_IDLE) &&
                       (state_q != S_INIT)) || pend_q;
   assign bus.ready = (state_q == S_IDLE) && !pend_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      half_d  = half_q;
      bit_d   = bit_q;
      widx_d  = widx_q;
      init_d  = init_q;
      pend_d  = pend_q;
      dig_d   = dig_q;

      if (!bus.ena)
         pend_d = 1'b0;
      else if (bus.start && !init_q &&
               state_q != S_IDLE &&
               state_q != S_INIT)
         pend_d = 1'b1;

      unique case (state_q)
         S_INIT: begin
            state_d = S_LOAD;
            widx_d  = 3'd0;
            init_d  = 1'b1;
            cnt_d   = 9'd0;
            half_d  = 1'b0;
            bit_d   = 4'd15;
         end
         S_IDLE: begin
            if (bus.ena && bus.start) begin
               state_d = S_LOAD;
               widx_d  = 3'd0;
               dig_d   = bus.digits_in;
            end
         end
         S_LOAD, S_SHIFT: begin
            state_d = S_SHIFT;
            if (cnt_q == DIV_LAST) begin
               cnt_d  = 9'd0;
               half_d = ~half_q;
               if (half_q) begin
                  if (bit_q == 4'd0)
                     state_d = S_GAP;
                  else
                     bit_d = bit_q - 4'd1;
               end
            end else begin
               cnt_d = cnt_q + 9'd1;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = 9'd0;
               half_d  = 1'b0;
               bit_d   = 4'd15;
               state_d = S_LOAD;
               if (init_q) begin
                  if (widx_q == INIT_END) begin
                     state_d = S_IDLE;
                     init_d  = 1'b0;
                  end else begin
                     widx_d = widx_q + 3'd1;
                  end
               end else if (widx_q == DIG_END) begin
                  // Queued refresh restarts with a fresh snapshot.
                  if (launch) begin
                     widx_d = 3'd0;
                     dig_d  = bus.digits_in;
                     pend_d = 1'b0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  widx_d = widx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 9'd1;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_INIT;
         cnt_q   <= 9'd0;
         half_q  <= 1'b0;
         bit_q   <= 4'd15;
         widx_q  <= 3'd0;
         init_q  <= 1'b1;
         pend_q  <= 1'b0;
         dig_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         half_q  <= half_d;
         bit_q   <= bit_d;
         widx_q  <= widx_d;
         init_q  <= init_d;
         pend_q  <= pend_d;
         dig_q   <= dig_d;
      end
   end

endmodule
